// File: rtl/fetch_if.sv
// fetch_if: bundle between the fetch stage, its decoder and the instruction ROM.
// The slave modport is the fetch unit's view. The master modport is the
// environment's view: the decoder controls, the ROM read data and everything
// the fetch unit reports back.
interface fetch_if;
    logic        en;
    logic        load_pc;
    logic        load_linkreg;
    logic        PC_source;
    logic [15:0] new_pc;
    logic [15:0] new_linkreg;
    logic [15:0] rom_addr;
    logic [20:0] rom_data;
    logic [20:0] INS;
    logic [15:0] INS_addr;
    logic        ins_valid;
    logic [15:0] link_top;
    logic [4:0]  stack_level;
    logic        stack_err;

    modport slave (
        input  en, load_pc, load_linkreg, PC_source, new_pc, new_linkreg, rom_data,
        output rom_addr, INS, INS_addr, ins_valid, link_top, stack_level, stack_err
    );

    modport master (
        output en, load_pc, load_linkreg, PC_source, new_pc, new_linkreg, rom_data,
        input  rom_addr, INS, INS_addr, ins_valid, link_top, stack_level, stack_err
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of instruction_decoder.
// Holds the PC and the link storage, and drives a synchronous ROM.
// rom_addr is combinational, so a jump or return decided this cycle fetches
// its target right away and the decoder sees no bubble.
// Optional feature: define LINK_STACK_EN to replace the single link register
// with a STACK_DEPTH-entry circular LIFO that has overflow/underflow reporting.
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          STACK_DEPTH = 8,
    parameter logic [20:0] NOP_WORD    = 21'h1F0000
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.slave bus
);
    localparam logic [4:0] DEPTH_L = 5'(STACK_DEPTH);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg;
    logic [15:0] nxt;
    logic [15:0] link_top;
    logic        accept;
    logic        do_call;

    // State register: BOOT until the first enabled edge, RUN afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= BOOT;
        else     state_reg <= state_next;
    end

    // Next state and next fetch address; decoder controls count only when accepted
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        nxt        = pc_reg;
        case (state_reg)
            BOOT: begin
                nxt = RESET_PC;
                if (bus.en) state_next = RUN;
            end
            RUN: begin
                accept = bus.en;
                if (accept && bus.load_pc && bus.PC_source) nxt = link_top;
                else if (accept && bus.load_pc)             nxt = bus.new_pc;
                else if (accept)                            nxt = pc_reg + 16'd1;
                else                                        nxt = pc_reg;
            end
            default: begin
                state_next = BOOT;
                nxt        = RESET_PC;
            end
        endcase
    end

    // pc tracks the address whose data the ROM is returning this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_reg <= RESET_PC;
        else     pc_reg <= nxt;
    end

    assign do_call       = accept & bus.load_linkreg;
    assign bus.rom_addr  = nxt;
    assign bus.ins_valid = accept;
    assign bus.INS       = accept ? bus.rom_data : NOP_WORD;
    assign bus.INS_addr  = pc_reg;
    assign bus.link_top  = link_top;

`ifdef LINK_STACK_EN
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [15:0]      stack_reg [STACK_DEPTH];
    logic [PTR_W-1:0] sp_reg, sp_next;       // index of the top entry
    logic [4:0]       level_reg, level_next;
    logic             err_reg, err_next;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic             do_ret;

    assign do_ret = accept & bus.load_pc & bus.PC_source;

    // Stack bookkeeping: push wraps over the oldest entry when full, pop on empty only flags
    always_comb begin
        sp_next    = sp_reg;
        level_next = level_reg;
        err_next   = err_reg;
        wr_en      = 1'b0;
        wr_idx     = sp_reg + 1'b1;
        if (do_call && do_ret) begin
            // A call that is also a return swaps the top in place
            wr_en  = 1'b1;
            wr_idx = sp_reg;
            if (level_reg == 5'd0) err_next = 1'b1;
        end else if (do_call) begin
            wr_en   = 1'b1;
            wr_idx  = sp_reg + 1'b1;
            sp_next = sp_reg + 1'b1;
            if (level_reg == DEPTH_L) err_next   = 1'b1;
            else                      level_next = level_reg + 5'd1;
        end else if (do_ret) begin
            if (level_reg == 5'd0) begin
                err_next = 1'b1;
            end else begin
                sp_next    = sp_reg - 1'b1;
                level_next = level_reg - 5'd1;
            end
        end
    end

    // Stack pointer, fill level and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_reg    <= '0;
            level_reg <= 5'd0;
            err_reg   <= 1'b0;
        end else begin
            sp_reg    <= sp_next;
            level_reg <= level_next;
            err_reg   <= err_next;
        end
    end

    // Stack entries; all cleared on reset so link_top is deterministic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack_reg[i] <= 16'h0000;
        end else if (wr_en) begin
            stack_reg[wr_idx] <= bus.new_linkreg;
        end
    end

    // An empty stack returns to the boot address
    assign link_top        = (level_reg == 5'd0) ? RESET_PC : stack_reg[sp_reg];
    assign bus.stack_level = level_reg;
    assign bus.stack_err   = err_reg;
`else
    logic [15:0] link_reg;
    logic        called_reg;

    // Single link register: each call overwrites the return address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_reg   <= 16'h0000;
            called_reg <= 1'b0;
        end else if (do_call) begin
            link_reg   <= bus.new_linkreg;
            called_reg <= 1'b1;
        end
    end

    assign link_top        = link_reg;
    // A zero-depth build would hold no link at all
    assign bus.stack_level = (called_reg && DEPTH_L != 5'd0) ? 5'd1 : 5'd0;
    assign bus.stack_err   = 1'b0;
`endif
endmodule
